// File: rtl/md_issue_ctrl_if.sv
// EX <-> multiply/divide controller handshake bundle.
// The flush signal exists only when MDU_FLUSH_EN is defined.
interface md_issue_ctrl_if;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic        stall;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MDU_FLUSH_EN
  modport master (output op_valid, op, opa, opb, flush,
                  input  stall, busy, rd_data, hi, lo);
  modport slave  (input  op_valid, op, opa, opb, flush,
                  output stall, busy, rd_data, hi, lo);
`else
  modport master (output op_valid, op, opa, opb,
                  input  stall, busy, rd_data, hi, lo);
  modport slave  (input  op_valid, op, opa, opb,
                  output stall, busy, rd_data, hi, lo);
`endif
endinterface

// File: rtl/md_issue_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, times MULT/DIV latency, stalls colliding HI/LO ops.
// Optional MDU_FLUSH_EN adds a flush input that cancels in-flight or presented ops.
//  state | meaning
//  IDLE  | no op in flight; MT*/MF* complete immediately, MULT/DIV start
//  BUSY  | op in flight, cnt counts down; commit to HI/LO when cnt==1
module md_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic           clk,
  input logic           rst,
  md_issue_ctrl_if.slave md
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi, res_lo;
  logic [63:0] prod;
  logic        is_md, is_start, cancel;

  assign is_md    = md.op_valid && (md.op >= 4'd1) && (md.op <= 4'd8);
  assign is_start = md.op_valid && (md.op >= 4'd1) && (md.op <= 4'd4);

`ifdef MDU_FLUSH_EN
  assign cancel = md.flush;
`else
  assign cancel = 1'b0;
`endif

  assign md.stall   = is_md && (state == BUSY);
  assign md.busy    = (state == BUSY);
  assign md.rd_data = (md.op == 4'd7) ? hi_q : lo_q;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    prod   = '0;
    case (op_q)
      4'd1: begin
        prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        {res_hi, res_lo} = prod;
      end
      4'd2: begin
        prod = {32'd0, a_q} * {32'd0, b_q};
        {res_hi, res_lo} = prod;
      end
      4'd3: begin
        // Zero divisor and INT_MIN/-1 are pinned explicitly rather than left to the divider
        if (b_q == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a_q;
        end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(a_q) / $signed(b_q);
          res_hi = $signed(a_q) % $signed(b_q);
        end
      end
      4'd4: begin
        if (b_q == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a_q;
        end else begin
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md.op_valid && !cancel) begin
            if (is_start) begin
              op_q  <= md.op;
              a_q   <= md.opa;
              b_q   <= md.opb;
              cnt   <= (md.op <= 4'd2) ? 5'(MUL_CYCLES) : 5'(DIV_CYCLES);
              state <= BUSY;
            end else if (md.op == 4'd5) begin
              hi_q <= md.opa;
            end else if (md.op == 4'd6) begin
              lo_q <= md.opa;
            end
          end
        end
        BUSY: begin
          if (cancel) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == 5'd1) begin
            hi_q  <= res_hi;
            lo_q  <= res_lo;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: latency, stall, arithmetic corner cases, reset and optional flush.
module tb_md_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_cnt;

  always #5 clk = ~clk;

  md_issue_ctrl_if bus ();

  md_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = v;
    bus.op       = o;
    bus.opa      = a;
    bus.opb      = b;
    #1;
  endtask

  // Present a start for one cycle, then scramble operands; returns in cycle t+1
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, o, a, b);
    tick();
    drive(1'b0, 4'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op       = 4'd0;
    bus.opa      = 32'd0;
    bus.opb      = 32'd0;
`ifdef MDU_FLUSH_EN
    bus.flush    = 1'b0;
`endif
    tick_n(2);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    rst = 1'b1;
    tick();

    // MULT -3 * 7, busy t+1..t+5, MFLO in t+6 without stall
    issue(4'd1, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mult_busy_%0d", i + 1), {31'd0, bus.busy}, 32'd1);
      tick();
    end
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    check("mult_busy_done", {31'd0, bus.busy}, 32'd0);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFEB);
    check("mult_mflo_stall", {31'd0, bus.stall}, 32'd0);
    check("mult_mflo_data", bus.rd_data, 32'hFFFF_FFEB);
    tick();

    // MULTU with a NOP overlapping the busy window
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    drive(1'b1, 4'd0, 32'd0, 32'd0);
    check("nop_no_stall", {31'd0, bus.stall}, 32'd0);
    check("multu_busy", {31'd0, bus.busy}, 32'd1);
    drive(1'b1, 4'd12, 32'd0, 32'd0);
    check("op12_no_stall", {31'd0, bus.stall}, 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick_n(5);
    check("multu_hi", bus.hi, 32'd1);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // Back-to-back signed DIV -7/2 right after commit; operands scrambled while busy
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    tick_n(10);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

    // DIVU 100/7 followed by MFLO, which must stall for 10 cycles
    issue(4'd4, 32'd100, 32'd7);
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    stall_cnt = 0;
    while (bus.stall === 1'b1 && stall_cnt < 40) begin
      stall_cnt++;
      tick();
    end
    check("divu_stall_cycles", 32'(stall_cnt), 32'd10);
    check("divu_rd_data", bus.rd_data, 32'd14);
    check("divu_hi", bus.hi, 32'd2);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);

    // Signed overflow and divide by zero
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    tick_n(10);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'd0);
    issue(4'd3, 32'd5, 32'd0);
    tick_n(10);
    check("div_zero_lo", bus.lo, 32'hFFFF_FFFF);
    check("div_zero_hi", bus.hi, 32'd5);

    // MTHI then MFHI, neither stalls
    drive(1'b1, 4'd5, 32'h0000_1234, 32'd0);
    check("mthi_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    check("mfhi_stall", {31'd0, bus.stall}, 32'd0);
    check("mfhi_data", bus.rd_data, 32'h0000_1234);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);

    // Reset in the 3rd busy cycle of a DIV
    issue(4'd3, 32'd100, 32'd3);
    tick_n(2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    check("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);

`ifdef MDU_FLUSH_EN
    // MTLO 9, MULT 2*3 flushed in its 2nd busy cycle
    drive(1'b1, 4'd6, 32'd9, 32'd0);
    tick();
    issue(4'd1, 32'd2, 32'd3);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_lo", bus.lo, 32'd9);
    check("flush_hi", bus.hi, 32'd0);
    tick_n(5);
    check("flush_no_late_commit", bus.lo, 32'd9);
    // Flush in IDLE suppresses an MTLO write
    drive(1'b1, 4'd6, 32'd77, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    check("flush_idle_lo", bus.lo, 32'd9);
    check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
